// File: rtl/toggle_cover_drain.sv
// Sticky first-hit recorder for one group of toggle-coverage points; each newly
// covered global index is drained exactly once per epoch over a valid/ready stream.
module toggle_cover_drain #(
    parameter int WIDTH       = 62,
    parameter int COVER_TOTAL = 8940,
    parameter int COVER_INDEX = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           valid,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_index,
    output logic [$clog2(WIDTH+1)-1:0] hit_count,
    output logic                       all_hit
);

    localparam int CW = $clog2(WIDTH + 1);

    if ((COVER_INDEX + WIDTH > COVER_TOTAL) || (WIDTH < 1)) begin : g_param_check
        $error("toggle_cover_drain: COVER_INDEX+WIDTH exceeds COVER_TOTAL or WIDTH < 1");
    end

    logic [WIDTH-1:0] seen_q, seen_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      out_index_q, out_index_d;
    logic [CW-1:0]    count_q, count_d;

    logic [WIDTH-1:0] new_hits;
    logic [CW-1:0]    new_pop;
    logic             found;
    int unsigned      pick;
    logic             load;

    always_comb begin
        new_hits = valid & ~seen_q;
        new_pop  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            new_pop = new_pop + CW'(new_hits[i]);
        end
    end

    // Priority scan of pend as it stood before this edge; fresh hits wait a cycle.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && pend_q[i]) begin
                found = 1'b1;
                pick  = i;
            end
        end
    end

    assign load = !out_valid_q || out_ready;

    always_comb begin
        seen_d      = seen_q;
        pend_d      = pend_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;

        if (load) begin
            if (found && !clear) begin
                out_valid_d  = 1'b1;
                out_index_d  = 64'(COVER_INDEX) + 64'(pick);
                pend_d[pick] = 1'b0;
            end else begin
                out_valid_d  = 1'b0;
            end
        end

        // Clear discards pending points but lets a held output finish its transfer.
        if (clear) begin
            seen_d  = '0;
            pend_d  = '0;
            count_d = '0;
        end else begin
            seen_d  = seen_q | new_hits;
            pend_d  = pend_d | new_hits;
            count_d = count_q + new_pop;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen_q      <= '0;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            count_q     <= '0;
        end else begin
            seen_q      <= seen_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign hit_count = count_q;
    assign all_hit   = (count_q == CW'(WIDTH));

endmodule

// File: tb/tb_toggle_cover_drain.sv
// Directed bench for toggle_cover_drain with COVER_INDEX=100, WIDTH=62.
module tb_toggle_cover_drain;

    localparam int WIDTH = 62;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] valid;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_index;
    logic [CW-1:0]    hit_count;
    logic             all_hit;

    int n_vec;
    int n_err;
    logic [63:0] xfers[$];

    toggle_cover_drain #(
        .WIDTH      (WIDTH),
        .COVER_TOTAL(8940),
        .COVER_INDEX(100)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .valid    (valid),
        .clear    (clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_index(out_index),
        .hit_count(hit_count),
        .all_hit  (all_hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A handshake sampled just before the edge is a transfer on that edge.
    task automatic tick();
        if (out_valid === 1'b1 && out_ready === 1'b1) xfers.push_back(out_index);
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        valid = '0;
        clear = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_ovalid", 64'(out_valid), 64'd0);
        chk("rst_oindex", out_index, 64'd0);
        chk("rst_count", 64'(hit_count), 64'd0);
        chk("rst_allhit", 64'(all_hit), 64'd0);
        reset = 1'b0;
        tick();

        // Single point held for 10 cycles
        xfers.delete();
        v = '0; v[5] = 1'b1; valid = v;
        tick();
        chk("t1_count_e1", 64'(hit_count), 64'd1);
        chk("t1_ovalid_e1", 64'(out_valid), 64'd0);
        tick();
        chk("t1_ovalid_e2", 64'(out_valid), 64'd1);
        chk("t1_oindex_e2", out_index, 64'd105);
        for (int i = 0; i < 8; i++) tick();
        valid = '0;
        tick();
        tick();
        chk("t1_nxfer", 64'(xfers.size()), 64'd1);
        chk("t1_xfer0", xfers[0], 64'd105);
        chk("t1_count_end", 64'(hit_count), 64'd1);
        chk("t1_ovalid_end", 64'(out_valid), 64'd0);
        chk("t1_index_hold", out_index, 64'd105);

        // Multi-hit ordering
        do_clear();
        chk("t2_clr_count", 64'(hit_count), 64'd0);
        v = '0; v[61] = 1'b1; v[7] = 1'b1; v[0] = 1'b1; valid = v;
        tick();
        valid = '0;
        chk("t2_count", 64'(hit_count), 64'd3);
        tick();
        chk("t2_idx0", out_index, 64'd100);
        tick();
        chk("t2_idx1", out_index, 64'd107);
        tick();
        chk("t2_idx2", out_index, 64'd161);
        chk("t2_ov2", 64'(out_valid), 64'd1);
        tick();
        chk("t2_ov_end", 64'(out_valid), 64'd0);

        // Backpressure
        do_clear();
        out_ready = 1'b0;
        valid = v;
        tick();
        valid = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_ov", 64'(out_valid), 64'd1);
            chk("t3_stall_idx", out_index, 64'd100);
            if (i < 4) tick();
        end
        out_ready = 1'b1;
        xfers.delete();
        tick();
        chk("t3_idx1", out_index, 64'd107);
        tick();
        chk("t3_idx2", out_index, 64'd161);
        tick();
        tick();
        chk("t3_nxfer", 64'(xfers.size()), 64'd3);
        chk("t3_x0", xfers[0], 64'd100);
        chk("t3_x1", xfers[1], 64'd107);
        chk("t3_x2", xfers[2], 64'd161);

        // Full coverage and saturation
        do_clear();
        chk("t4_allhit_pre", 64'(all_hit), 64'd0);
        valid = '1;
        tick();
        valid = '0;
        chk("t4_count", 64'(hit_count), 64'd62);
        chk("t4_allhit", 64'(all_hit), 64'd1);
        xfers.delete();
        for (int i = 0; i < 64; i++) tick();
        chk("t4_nxfer", 64'(xfers.size()), 64'd62);
        for (int i = 0; i < 62; i++) chk("t4_order", xfers[i], 64'(100 + i));
        valid = '1;
        tick();
        valid = '0;
        tick();
        tick();
        chk("t4_sat_count", 64'(hit_count), 64'd62);
        chk("t4_sat_allhit", 64'(all_hit), 64'd1);
        chk("t4_sat_ov", 64'(out_valid), 64'd0);

        // Clear mid-drain
        out_ready = 1'b0;
        do_clear();
        chk("t5_allhit_clr", 64'(all_hit), 64'd0);
        v = '0; v[3] = 1'b1; v[9] = 1'b1; valid = v;
        tick();
        valid = '0;
        tick();
        chk("t5_held_idx", out_index, 64'd103);
        chk("t5_count_pre", 64'(hit_count), 64'd2);
        do_clear();
        chk("t5_ov_kept", 64'(out_valid), 64'd1);
        chk("t5_idx_kept", out_index, 64'd103);
        chk("t5_count_clr", 64'(hit_count), 64'd0);
        out_ready = 1'b1;
        xfers.delete();
        tick();
        chk("t5_ov_after", 64'(out_valid), 64'd0);
        tick();
        tick();
        chk("t5_nxfer", 64'(xfers.size()), 64'd1);
        chk("t5_x0", xfers[0], 64'd103);
        v = '0; v[3] = 1'b1; valid = v;
        tick();
        valid = '0;
        tick();
        chk("t5_rehit_idx", out_index, 64'd103);
        chk("t5_rehit_ov", 64'(out_valid), 64'd1);
        tick();
        chk("t5_nxfer2", 64'(xfers.size()), 64'd2);

        // Async reset mid-operation
        out_ready = 1'b0;
        v = '0; v[10] = 1'b1; valid = v;
        tick();
        valid = '0;
        tick();
        chk("t6_pre_idx", out_index, 64'd110);
        chk("t6_pre_count", 64'(hit_count), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_ov", 64'(out_valid), 64'd0);
        chk("t6_async_count", 64'(hit_count), 64'd0);
        chk("t6_async_allhit", 64'(all_hit), 64'd0);
        valid = '1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("t6_ign_count", 64'(hit_count), 64'd0);
        chk("t6_ign_ov", 64'(out_valid), 64'd0);
        valid = '0;
        reset = 1'b0;
        tick();
        v = '0; v[10] = 1'b1; valid = v;
        tick();
        valid = '0;
        chk("t6_rehit_count", 64'(hit_count), 64'd1);
        tick();
        chk("t6_rehit_ov", 64'(out_valid), 64'd1);
        chk("t6_rehit_idx", out_index, 64'd110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/toggle_cover_drain.md
Name: toggle_cover_drain

Overview:
- Synthesizable receiving end for one group of toggle-coverage points.
- Consumes the same per-cycle WIDTH-bit hit vector that a toggle coverage reporter consumes, but does not call DPI per hit. Instead it records first hits in a sticky bitmap and drains each newly covered global index exactly once over a valid/ready stream.
- Sits between instrumented RTL and an on-chip or formal coverage collector, and works with or without DIFFTEST.

Parameters:
- WIDTH, 62: number of coverage points in this group.
- COVER_TOTAL, 8940: total coverage points design-wide; used only for the range check.
- COVER_INDEX, 0: global index of bit 0 of valid.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid  input  WIDTH  per-cycle hit vector; bit i means point COVER_INDEX+i was hit this cycle.
- clear  input  1  synchronous restart of coverage collection.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- out_index  output  64  global cover index (COVER_INDEX+i), zero-extended.
- hit_count  output  $clog2(WIDTH+1)  distinct points seen since reset or last clear.
- all_hit  output  1  high when hit_count equals WIDTH.

Behaviour:
- State:
  - seen[WIDTH]: sticky first-hit map.
  - pend[WIDTH]: seen but not yet loaded into the output register.
  - Output holding register: out_valid, out_index.
  - hit_count.
- Reset (async assert, sync-safe deassert): seen=0, pend=0, out_valid=0, out_index=0, hit_count=0, all_hit=0. While reset is high, valid and clear are ignored.
- Capture, each edge:
  - new = valid & ~seen.
  - seen |= new; pend |= new.
  - hit_count += popcount(new).
  - Bits already in seen never re-enter pend, so each point is reported at most once per collection epoch.
- Load:
  - The output register loads when out_valid=0, or when out_valid&&out_ready (a transfer) happens this cycle.
  - It loads the lowest-numbered set bit k of pend as sampled before this edge. out_valid=1, out_index=COVER_INDEX+k, and pend[k] is cleared.
  - If pend is empty at a load opportunity, out_valid=0 and out_index holds its last value.
- Latency and throughput:
  - valid[i] high in cycle N sets pend[i] at edge N.
  - out_valid/out_index for i are visible after edge N+1 if the register is free.
  - Back-to-back transfers run at 1 index per cycle while out_ready=1.
- Stream rules:
  - out_valid, once high, stays high with out_index stable until a transfer occurs.
  - out_valid is never combinationally dependent on out_ready.
- Simultaneous events:
  - A new hit on bit k in the same cycle as pend being scanned is not visible to that scan; it is picked up on a later load.
  - A transfer and a new load on the same edge is legal, giving a continuous stream.
- all_hit is combinational from hit_count==WIDTH and saturates there; hit_count never exceeds WIDTH.
- Clear (synchronous, has priority over capture on the same edge):
  - seen=0, pend=0, hit_count=0. valid in that cycle is discarded.
  - A held out_valid/out_index is NOT dropped; it completes normally. That point may be reported again in the new epoch.
- Width: index arithmetic is done at 64 bits; no wrap for legal parameters.
- Elaboration: fail elaboration if COVER_INDEX+WIDTH > COVER_TOTAL or WIDTH < 1.
- Internal storage is not exposed.

Test Plan:
- Single point, held hit:
  - Stimulus: COVER_INDEX=100, out_ready=1, valid[5]=1 held for 10 cycles.
  - Response: exactly one transfer with out_index=105, 2 edges after first assertion. hit_count=1 thereafter.
- Multi-hit ordering:
  - Stimulus: one cycle of valid = bits {61,7,0}, out_ready=1, COVER_INDEX=100.
  - Response: transfers 100, 107, 161 on consecutive cycles. hit_count=3.
- Backpressure:
  - Stimulus: same multi-hit, with out_ready=0 for 5 cycles, then 1.
  - Response: out_valid=1 and out_index=100 stable for all 5 stalled cycles, then 107 and 161 follow with no loss and no duplicates.
- Full coverage:
  - Stimulus: valid all-ones for one cycle, out_ready=1.
  - Response: 62 transfers COVER_INDEX+0..61 in order. hit_count=62 and all_hit=1 after the capture edge.
- Clear mid-drain:
  - Stimulus: hit bits {3,9}; assert clear while out_index=103 is held with out_ready=0; then raise out_ready.
  - Response: 103 still transfers, 109 is never sent, hit_count=0. Re-hitting bit 3 later yields 103 again.
- Async reset mid-operation:
  - Stimulus: assert reset between edges while out_valid=1.
  - Response: out_valid=0, hit_count=0, all_hit=0 immediately. valid ignored while reset is high. After release, previously seen bits report again on hit.
